product_term_config_loader: RTL and testbench
=============================================

// Module: product_term_config_loader
//
// PURPOSE
// - Loads the mask configuration for a bank of product terms from a serial bitstream.
// - Sits between the programming interface and the product_term instances of one macrocell.
// - Accepts bits through a valid/ready handshake into a shadow register.
// - Commits the complete bank atomically, so the product terms never see a partial configuration.
//
// PARAMETERS
// - input_signal_count  88  width of one product term's configuration word
// - product_term_count  5   product terms per bank (one macrocell)
//
// PORTS
// - clock                clock   in   1      rising-edge clock
// - reset_n              reset   in   1      asynchronous, active-low reset
// - start                in   1      one-cycle pulse: begin a load session
// - abort                in   1      one-cycle pulse: cancel the session in progress
// - bit_data             in   1      serial configuration bit
// - bit_valid            in   1      bit_data is valid
// - bit_ready            out  1      loader accepts a bit; a transfer occurs when valid & ready
// - busy                 out  1      high while a session is in progress
// - done                 out  1      one-cycle pulse after a successful commit
// - error                out  1      sticky parity error (tied 0 without the macro)
// - configuration_valid  out  1      an active configuration has been committed since reset
// - configuration        out  product_term_count*input_signal_count
//                                    active masks; term t occupies bits [t*W +: W], W = input_signal_count
//
// BEHAVIOUR
// - Reset values:
//   - configuration is all ones (every maskable input ignored).
//   - busy, done, error, configuration_valid and bit_ready are all 0.
//   - The FSM is in IDLE.
// - FSM states: IDLE, LOAD, PARITY (macro only), COMMIT.
//   - IDLE: `start` clears both counters and `error`, then moves to LOAD. bit_ready is 0.
//   - LOAD: bit_ready is 1. Each transfer writes shadow[term][bit] <= bit_data, LSB first.
//     - bit_index counts 0..W-1.
//     - At W-1, bit_index wraps to 0 and the state goes to PARITY (macro) or advances term_index.
//     - Transfer of bit W-1 of the last term (term_index = T-1), without the macro, goes to COMMIT.
//   - COMMIT: lasts exactly one cycle; bit_ready is 0.
//     - At the end of COMMIT: configuration <= shadow, done <= 1 for one cycle,
//       configuration_valid <= 1, then IDLE.
//   - busy is 1 in every state except IDLE.
// - Latency: last bit transferred in cycle k -> COMMIT in cycle k+1 -> new configuration and done visible in cycle k+2.
// - bit_valid outside LOAD/PARITY: ignored, no transfer.
// - start while busy: ignored.
// - abort while busy: go to IDLE next cycle.
//   - Shadow is discarded; configuration is unchanged; no done pulse.
//   - abort takes priority over a simultaneous transfer.
// - abort in IDLE: no effect. start and abort together in IDLE: abort wins, stays IDLE.
// - Reset mid-session: immediate return to reset values; the previous configuration is lost (all ones).
// - Counters are sized $clog2(W) and $clog2(T), min 1 bit. They never exceed W-1 / T-1.
// - The active configuration only ever changes in COMMIT or reset.
//
// CONFIGURATION
// - Macro: PRODUCT_TERM_CONFIG_PARITY_EN
// - Defined:
//   - Each term's W data bits are followed by one parity bit, transferred in state PARITY (bit_ready = 1).
//   - Even parity over the W+1 bits is required.
//   - Match: next term in LOAD, or COMMIT after the last term.
//   - Mismatch: error <= 1, return to IDLE, no commit, no done; configuration unchanged.
//     error stays set until the next accepted start.
// - Undefined: no PARITY state; a session is exactly T*W transfers; error is constant 0.
//
// TESTING
// - Reset then idle:
//   - configuration = all ones (440 bits), configuration_valid = 0, bit_ready = 0.
// - Full load:
//   - start, then 440 back-to-back bits where term t bit b = (b == t).
//   - done is pulsed 2 cycles after the last bit; configuration[t*88 + t] = 1 and all other bits 0.
// - Throttled handshake: bit_valid toggles every cycle over the same stream.
//   - Identical final configuration; done pulses once.
// - Abort after 200 bits:
//   - busy falls next cycle; configuration keeps its prior value; no done.
//   - A fresh start plus 440 bits then commits normally.
// - Simultaneous events: start while busy is ignored (counters unaffected); abort on the cycle of the last bit prevents the commit.
// - Parity (macro):
//   - Term 2 has 3 ones in its data and parity bit 0 -> error = 1 and IDLE; configuration unchanged.
//   - Next start clears error.

Source files
------------

// File: rtl/product_term_config_loader_if.sv
// Programming-side bundle for product_term_config_loader: serial bit handshake,
// session control, status and the committed mask bank.
interface product_term_config_loader_if #(
  parameter int input_signal_count = 88,
  parameter int product_term_count = 5
);
  logic start;
  logic abort;
  logic bit_data;
  logic bit_valid;
  logic bit_ready;
  logic busy;
  logic done;
  logic error;
  logic configuration_valid;
  logic [product_term_count*input_signal_count-1:0] configuration;

  modport master (
    output start, abort, bit_data, bit_valid,
    input  bit_ready, busy, done, error, configuration_valid, configuration
  );

  modport slave (
    input  start, abort, bit_data, bit_valid,
    output bit_ready, busy, done, error, configuration_valid, configuration
  );
endinterface

// File: rtl/product_term_config_loader.sv
// Serial loader for one macrocell's product-term masks. Bits are shifted LSB
// first into a shadow bank and the whole bank is copied to the active
// configuration in a single COMMIT cycle, so consumers never see a partial load.
// Optional per-term even-parity checking: define PRODUCT_TERM_CONFIG_PARITY_EN.
module product_term_config_loader #(
  parameter int input_signal_count = 88,
  parameter int product_term_count = 5
) (
  input logic                         clock,
  input logic                         reset_n,
  product_term_config_loader_if.slave bus
);

  localparam int W  = input_signal_count;
  localparam int T  = product_term_count;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int TW = (T > 1) ? $clog2(T) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [TW-1:0] TERM_LAST = TW'(T - 1);

`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
  typedef enum logic [1:0] {IDLE, LOAD, PARITY, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

  state_t          state, state_next;
  logic [BW-1:0]   bit_index;
  logic [TW-1:0]   term_index;
  logic [W-1:0]    shadow [T];
  logic            ready_c;
  logic            start_accept;
  logic            load_xfer;
  logic            commit_fire;
  logic            bit_is_last;
  logic            term_is_last;

  assign start_accept = (state == IDLE) && bus.start && !bus.abort;
  assign load_xfer    = (state == LOAD) && bus.bit_valid && !bus.abort;
  assign commit_fire  = (state == COMMIT) && !bus.abort;
  assign bit_is_last  = (bit_index == BIT_LAST);
  assign term_is_last = (term_index == TERM_LAST);

`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
  logic parity_acc;
  logic parity_xfer;
  logic parity_bad;
  logic error_q;

  assign parity_xfer = (state == PARITY) && bus.bit_valid && !bus.abort;
  // Even parity over data plus parity bit: running XOR must end at zero.
  assign parity_bad  = parity_acc ^ bus.bit_data;
  assign bus.error   = error_q;
`else
  assign bus.error   = 1'b0;
`endif

  assign bus.bit_ready = ready_c;
  assign bus.busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake decode; abort out-ranks any transfer in the same cycle.
  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) state_next = LOAD;
      end
      LOAD: begin
        ready_c = 1'b1;
        if (bus.abort) begin
          state_next = IDLE;
        end else if (bus.bit_valid && bit_is_last) begin
`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
          state_next = PARITY;
`else
          if (term_is_last) state_next = COMMIT;
`endif
        end
      end
`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
      PARITY: begin
        ready_c = 1'b1;
        if (bus.abort) begin
          state_next = IDLE;
        end else if (bus.bit_valid) begin
          if (parity_bad)        state_next = IDLE;
          else if (term_is_last) state_next = COMMIT;
          else                   state_next = LOAD;
        end
      end
`endif
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shadow bank and bit/term counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_index  <= '0;
      term_index <= '0;
      for (int unsigned t = 0; t < T; t++) shadow[t] <= '0;
    end else if (start_accept) begin
      bit_index  <= '0;
      term_index <= '0;
    end else if (load_xfer) begin
      shadow[term_index][bit_index] <= bus.bit_data;
      if (bit_is_last) begin
        bit_index <= '0;
`ifndef PRODUCT_TERM_CONFIG_PARITY_EN
        if (!term_is_last) term_index <= term_index + TW'(1);
`endif
      end else begin
        bit_index <= bit_index + BW'(1);
      end
    end
`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
    else if (parity_xfer && !parity_bad && !term_is_last) begin
      term_index <= term_index + TW'(1);
    end
`endif
  end

`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
  // Running parity per term and the sticky error flag, cleared by an accepted start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_acc <= 1'b0;
      error_q    <= 1'b0;
    end else if (start_accept) begin
      parity_acc <= 1'b0;
      error_q    <= 1'b0;
    end else if (load_xfer) begin
      parity_acc <= parity_acc ^ bus.bit_data;
    end else if (parity_xfer) begin
      parity_acc <= 1'b0;
      if (parity_bad) error_q <= 1'b1;
    end
  end
`endif

  // Atomic commit of the shadow bank into the active configuration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.configuration       <= '1;
      bus.configuration_valid <= 1'b0;
      bus.done                <= 1'b0;
    end else begin
      bus.done <= commit_fire;
      if (commit_fire) begin
        for (int unsigned t = 0; t < T; t++) bus.configuration[t*W +: W] <= shadow[t];
        bus.configuration_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_product_term_config_loader.sv
// Self-checking bench for product_term_config_loader: a transfer-count model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_product_term_config_loader;

  localparam int W = 88;
  localparam int T = 5;
  localparam int N = W * T;
`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
  localparam int STRIDE = W + 1;
`else
  localparam int STRIDE = W;
`endif
  localparam int L = T * STRIDE;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  product_term_config_loader_if #(.input_signal_count(W), .product_term_count(T)) bus ();

  product_term_config_loader #(.input_signal_count(W), .product_term_count(T)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic cmp_on = 1'b0;

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkv(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Data patterns: 0 = diagonal, 1 = every third position, 2 = diagonal with term 2 = three ones.
  function automatic logic data_bit(input int pat, input int t, input int b);
    case (pat)
      0:       return (b == t);
      1:       return ((b + t) % 3) == 0;
      default: return (t == 2) ? (b < 3) : (b == t);
    endcase
  endfunction

  function automatic logic stream_bit(input int pat, input int p);
    int t;
    int b;
    logic par;
    t = p / STRIDE;
    b = p % STRIDE;
    if (b < W) return data_bit(pat, t, b);
    par = 1'b0;
    for (int i = 0; i < W; i++) par ^= data_bit(pat, t, i);
    if (pat == 2 && t == 2) return 1'b0;
    return par;
  endfunction

  function automatic logic [N-1:0] exp_cfg(input int pat);
    logic [N-1:0] r;
    r = '0;
    for (int t = 0; t < T; t++)
      for (int b = 0; b < W; b++) r[t*W + b] = data_bit(pat, t, b);
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_cfg;
  logic         m_cfgv, m_done, m_err, m_active, m_commit, m_par;
  int           m_count;
  logic [W-1:0] m_term [T];

  task automatic model_step();
    int t;
    int b;
    if (!reset_n) begin
      m_cfg = '1; m_cfgv = 0; m_done = 0; m_err = 0;
      m_active = 0; m_commit = 0; m_par = 0; m_count = 0;
      return;
    end
    m_done = 0;
    if (m_commit) begin
      m_commit = 0;
      if (!bus.abort) begin
        for (int k = 0; k < T; k++) m_cfg[k*W +: W] = m_term[k];
        m_cfgv = 1;
        m_done = 1;
      end
    end else if (m_active) begin
      if (bus.abort) begin
        m_active = 0;
      end else if (bus.bit_valid) begin
        t = m_count / STRIDE;
        b = m_count % STRIDE;
        if (b < W) begin
          m_term[t][b] = bus.bit_data;
          m_par ^= bus.bit_data;
        end else begin
          if (m_par ^ bus.bit_data) begin
            m_err = 1;
            m_active = 0;
          end
          m_par = 0;
        end
        m_count++;
        if (m_active && m_count == L) begin
          m_active = 0;
          m_commit = 1;
        end
      end
    end else if (bus.start && !bus.abort) begin
      m_active = 1; m_count = 0; m_err = 0; m_par = 0;
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    model_step();
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_on) begin
      check1("busy", bus.busy, m_active || m_commit);
      check1("bit_ready", bus.bit_ready, m_active);
      check1("done", bus.done, m_done);
      check1("error", bus.error, m_err);
      check1("configuration_valid", bus.configuration_valid, m_cfgv);
      checkv("configuration", bus.configuration, m_cfg);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input int pat, input int from, input int to, input bit throttle, input bit abort_last);
    int p;
    int guard;
    logic tog;
    p = from; guard = 0; tog = 1'b0;
    while (p < to && guard < 4 * L) begin
      bus.bit_valid = throttle ? tog : 1'b1;
      tog = ~tog;
      bus.bit_data = stream_bit(pat, p);
      if (abort_last && bus.bit_valid && p == to - 1) bus.abort = 1'b1;
      tick();
      if (bus.bit_valid) p++;
      guard++;
    end
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
    bus.abort     = 1'b0;
    checki("send_complete", p, to);
  endtask

  logic [N-1:0] diag;
  int done_cnt;

  initial begin
    bus.start = 0; bus.abort = 0; bus.bit_data = 0; bus.bit_valid = 0;
    diag = '0;
    for (int t = 0; t < T; t++) diag[t*W + t] = 1'b1;

    repeat (3) tick();
    cmp_on = 1'b1;
    reset_n = 1'b1;
    tick();

    // Reset state
    checkv("reset_cfg", bus.configuration, {N{1'b1}});
    check1("reset_cfgv", bus.configuration_valid, 1'b0);
    check1("reset_ready", bus.bit_ready, 1'b0);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_error", bus.error, 1'b0);

    // Full back-to-back load, done exactly two cycles after the last bit
    pulse_start();
    check1("load_ready", bus.bit_ready, 1'b1);
    send(0, 0, L, 1'b0, 1'b0);
    check1("commit_cycle_done", bus.done, 1'b0);
    check1("commit_cycle_busy", bus.busy, 1'b1);
    tick();
    check1("done_pulse", bus.done, 1'b1);
    checkv("full_load_cfg", bus.configuration, diag);
    check1("full_load_cfgv", bus.configuration_valid, 1'b1);
    tick();

    // Throttled handshake
    pulse_start();
    send(0, 0, L, 1'b1, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    checki("throttled_done_count", done_cnt, 1);
    checkv("throttled_cfg", bus.configuration, diag);

    // Abort after 200 bits, then a fresh full load
    pulse_start();
    send(1, 0, 200, 1'b0, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check1("abort_busy", bus.busy, 1'b0);
    checkv("abort_cfg_kept", bus.configuration, diag);
    repeat (3) tick();
    pulse_start();
    send(1, 0, L, 1'b0, 1'b0);
    repeat (2) tick();
    checkv("reload_cfg", bus.configuration, exp_cfg(1));

    // start while busy is ignored
    pulse_start();
    send(0, 0, 100, 1'b0, 1'b0);
    bus.start = 1'b1;
    send(0, 100, 101, 1'b0, 1'b0);
    bus.start = 1'b0;
    send(0, 101, L, 1'b0, 1'b0);
    repeat (2) tick();
    checkv("start_busy_cfg", bus.configuration, diag);

    // abort on the cycle of the last bit blocks the commit
    pulse_start();
    send(1, 0, L, 1'b0, 1'b1);
    check1("abort_last_busy", bus.busy, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    checki("abort_last_no_done", done_cnt, 0);
    checkv("abort_last_cfg", bus.configuration, diag);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check1("start_abort_idle", bus.busy, 1'b0);

`ifdef PRODUCT_TERM_CONFIG_PARITY_EN
    // Parity mismatch on term 2
    pulse_start();
    send(2, 0, 3 * STRIDE, 1'b0, 1'b0);
    check1("parity_error", bus.error, 1'b1);
    check1("parity_idle", bus.busy, 1'b0);
    checkv("parity_cfg_kept", bus.configuration, diag);
    repeat (2) tick();
    pulse_start();
    check1("parity_error_cleared", bus.error, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
`endif

    // Reset mid-session
    pulse_start();
    send(1, 0, 50, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    checkv("midreset_cfg", bus.configuration, {N{1'b1}});
    check1("midreset_cfgv", bus.configuration_valid, 1'b0);
    check1("midreset_busy", bus.busy, 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
